// File: rtl/rv32_fxmadd_seq_ctrl.sv
// Sequencing controller for the multi-cycle fxmadd unit.
// Accepts CSR scale-table writes while idle, launches one operation at a
// time, stalls the exec stage until the result is ready, holds the result
// across downstream stalls, and counts the results that were consumed.
module rv32_fxmadd_seq_ctrl #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned SCALE_W = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               issue_valid,
  input  logic [2:0]         issue_scale_sel,
  input  logic               stop,
  input  logic               flush,
  input  logic               cfg_valid,
  input  logic [2:0]         cfg_idx,
  input  logic [SCALE_W-1:0] cfg_scale,
  output logic               cfg_ready,
  output logic               unit_start,
  output logic [2:0]         unit_selected_scale,
  output logic               unit_write_enable,
  output logic [SCALE_W-1:0] unit_new_scale,
  output logic               stall_req,
  output logic               result_valid,
  output logic [15:0]        op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Remaining BUSY cycles after launch; the launch cycle is the first of LATENCY.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic        hold_q, hold_d;
  logic [15:0] op_count_q;
  logic        consume;

  // Next-state and output decode; reset forces every output to its idle value.
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    sel_d               = sel_q;
    hold_d              = 1'b0;
    consume             = 1'b0;
    cfg_ready           = 1'b0;
    unit_start          = 1'b0;
    unit_write_enable   = 1'b0;
    unit_selected_scale = 3'd0;
    unit_new_scale      = '0;
    stall_req           = 1'b0;
    result_valid        = 1'b0;

    unique case (state_q)
      IDLE: begin
        stall_req = issue_valid && !flush;
        if (cfg_valid) begin
          // Table writes win over launches so the table never changes mid-op.
          cfg_ready           = 1'b1;
          unit_write_enable   = 1'b1;
          unit_selected_scale = cfg_idx;
          unit_new_scale      = cfg_scale;
        end else if (issue_valid && !flush && !hold_q) begin
          // hold_q blocks the instruction whose result was just consumed.
          unit_start          = 1'b1;
          unit_selected_scale = issue_scale_sel;
          sel_d               = issue_scale_sel;
          cnt_d               = CNT_INIT;
          state_d             = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_req           = 1'b1;
        unit_selected_scale = sel_q;
        if (flush) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
          // Counter reaches zero this cycle, so the result is ready next cycle.
          if (cnt_q <= 4'd1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        unit_selected_scale = sel_q;
        result_valid        = !flush;
        if (flush) begin
          state_d = IDLE;
        end else if (!stop) begin
          consume = 1'b1;
          hold_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!resetn) begin
      consume             = 1'b0;
      cfg_ready           = 1'b0;
      unit_start          = 1'b0;
      unit_write_enable   = 1'b0;
      unit_selected_scale = 3'd0;
      unit_new_scale      = '0;
      stall_req           = 1'b0;
      result_valid        = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= 3'd0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
    end
  end

  // Completed-operation counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_count_q <= 16'd0;
    end else if (consume) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;

endmodule

// File: tb/tb_rv32_fxmadd_seq_ctrl.sv
// Bench for rv32_fxmadd_seq_ctrl: two instances (LATENCY 3 and 1) checked
// every cycle against a transaction-level model, plus directed scenarios
// with hand-computed expectations.
module tb_rv32_fxmadd_seq_ctrl;

  localparam int LAT0 = 3;
  localparam int LAT1 = 1;
  localparam int SW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rstn, issue, stop, flush, cfgv;
  logic [2:0]    isel   [2];
  logic [2:0]    cidx   [2];
  logic [SW-1:0] cscale [2];
  logic [1:0]    cfg_ready, ustart, uwe, stall, resv;
  logic [2:0]    usel   [2];
  logic [SW-1:0] unew   [2];
  logic [15:0]   opc    [2];

  int checks = 0;
  int errors = 0;

  rv32_fxmadd_seq_ctrl #(.LATENCY(LAT0), .SCALE_W(SW)) u_dut0 (
    .clk(clk), .resetn(rstn[0]), .issue_valid(issue[0]), .issue_scale_sel(isel[0]),
    .stop(stop[0]), .flush(flush[0]), .cfg_valid(cfgv[0]), .cfg_idx(cidx[0]),
    .cfg_scale(cscale[0]), .cfg_ready(cfg_ready[0]), .unit_start(ustart[0]),
    .unit_selected_scale(usel[0]), .unit_write_enable(uwe[0]),
    .unit_new_scale(unew[0]), .stall_req(stall[0]), .result_valid(resv[0]),
    .op_count(opc[0])
  );

  rv32_fxmadd_seq_ctrl #(.LATENCY(LAT1), .SCALE_W(SW)) u_dut1 (
    .clk(clk), .resetn(rstn[1]), .issue_valid(issue[1]), .issue_scale_sel(isel[1]),
    .stop(stop[1]), .flush(flush[1]), .cfg_valid(cfgv[1]), .cfg_idx(cidx[1]),
    .cfg_scale(cscale[1]), .cfg_ready(cfg_ready[1]), .unit_start(ustart[1]),
    .unit_selected_scale(usel[1]), .unit_write_enable(uwe[1]),
    .unit_new_scale(unew[1]), .stall_req(stall[1]), .result_valid(resv[1]),
    .op_count(opc[1])
  );

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // Transaction-level model: an operation is either absent or has an age in
  // cycles since launch; its result is available once age reaches LATENCY.
  bit          m_act  [2];
  int          m_age  [2];
  logic [2:0]  m_sel  [2];
  logic [15:0] m_cnt  [2];
  bit          m_hold [2];
  bit          m_en   [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0; m_age[k] = 0; m_sel[k] = 3'd0;
      m_cnt[k] = 16'd0; m_hold[k] = 1'b0; m_en[k] = 1'b0;
    end
  end

  // Compare every output against the model, then advance the model by one cycle.
  always @(negedge clk) begin
    bit e_start, e_cfg, e_stall, e_res;
    for (int k = 0; k < 2; k++) begin
      if (m_en[k]) begin
        if (!rstn[k]) begin
          e_start = 1'b0; e_cfg = 1'b0; e_stall = 1'b0; e_res = 1'b0;
          chk("usel_in_reset", k, 32'(usel[k]), 32'd0);
          chk("unew_in_reset", k, 32'(unew[k]), 32'd0);
        end else if (!m_act[k]) begin
          e_cfg   = cfgv[k];
          e_start = issue[k] && !cfgv[k] && !flush[k] && !m_hold[k];
          e_stall = issue[k] && !flush[k];
          e_res   = 1'b0;
          if (cfgv[k]) begin
            chk("usel_cfg", k, 32'(usel[k]), 32'(cidx[k]));
            chk("unew_cfg", k, 32'(unew[k]), 32'(cscale[k]));
          end
        end else begin
          e_cfg   = 1'b0;
          e_start = 1'b0;
          e_stall = (m_age[k] < lat_of(k));
          e_res   = !e_stall && !flush[k];
          chk("usel_op", k, 32'(usel[k]), 32'(m_sel[k]));
        end
        chk("cfg_ready", k, 32'(cfg_ready[k]), 32'(e_cfg));
        chk("unit_write_enable", k, 32'(uwe[k]), 32'(e_cfg));
        chk("unit_start", k, 32'(ustart[k]), 32'(e_start));
        chk("stall_req", k, 32'(stall[k]), 32'(e_stall));
        chk("result_valid", k, 32'(resv[k]), 32'(e_res));
        chk("op_count", k, 32'(opc[k]), 32'(m_cnt[k]));
      end

      if (!rstn[k]) begin
        m_act[k] = 1'b0; m_age[k] = 0; m_sel[k] = 3'd0;
        m_cnt[k] = 16'd0; m_hold[k] = 1'b0; m_en[k] = 1'b1;
      end else if (!m_act[k]) begin
        if (issue[k] && !cfgv[k] && !flush[k] && !m_hold[k]) begin
          m_act[k] = 1'b1; m_age[k] = 1; m_sel[k] = isel[k];
        end
        m_hold[k] = 1'b0;
      end else if (m_age[k] < lat_of(k)) begin
        if (flush[k]) m_act[k] = 1'b0;
        else m_age[k] = m_age[k] + 1;
      end else begin
        if (flush[k]) begin
          m_act[k] = 1'b0;
        end else if (!stop[k]) begin
          m_cnt[k] = m_cnt[k] + 16'd1; m_act[k] = 1'b0; m_hold[k] = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs(input int k);
    issue[k] = 1'b0; isel[k] = 3'd0; stop[k] = 1'b0; flush[k] = 1'b0;
    cfgv[k] = 1'b0; cidx[k] = 3'd0; cscale[k] = '0;
  endtask

  task automatic check_zero_outputs(input string tag, input int k);
    chk({tag, "_unit_start"}, k, 32'(ustart[k]), 32'd0);
    chk({tag, "_write_enable"}, k, 32'(uwe[k]), 32'd0);
    chk({tag, "_cfg_ready"}, k, 32'(cfg_ready[k]), 32'd0);
    chk({tag, "_stall_req"}, k, 32'(stall[k]), 32'd0);
    chk({tag, "_result_valid"}, k, 32'(resv[k]), 32'd0);
    chk({tag, "_usel"}, k, 32'(usel[k]), 32'd0);
    chk({tag, "_unew"}, k, 32'(unew[k]), 32'd0);
  endtask

  // One cycle of reset with idle inputs; returns at the first cycle out of reset.
  task automatic do_reset(input int k);
    clear_inputs(k);
    rstn[k] = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset", k);
    tick();
    rstn[k] = 1'b1;
  endtask

  initial begin
    rstn = 2'b00;
    clear_inputs(0);
    clear_inputs(1);
    fork
      do_reset(0);
      do_reset(1);
    join

    // Basic operation, LATENCY 3, scale 2
    issue[0] = 1'b1; isel[0] = 3'd2;
    @(negedge clk);
    chk("basic_c0_start", 0, 32'(ustart[0]), 32'd1);
    chk("basic_c0_stall", 0, 32'(stall[0]), 32'd1);
    tick(); @(negedge clk);
    chk("basic_c1_start", 0, 32'(ustart[0]), 32'd0);
    chk("basic_c1_stall", 0, 32'(stall[0]), 32'd1);
    chk("basic_c1_usel", 0, 32'(usel[0]), 32'd2);
    tick(); @(negedge clk);
    chk("basic_c2_stall", 0, 32'(stall[0]), 32'd1);
    chk("basic_c2_result", 0, 32'(resv[0]), 32'd0);
    tick(); @(negedge clk);
    chk("basic_c3_result", 0, 32'(resv[0]), 32'd1);
    chk("basic_c3_stall", 0, 32'(stall[0]), 32'd0);
    chk("basic_c3_usel", 0, 32'(usel[0]), 32'd2);
    tick(); @(negedge clk);
    chk("basic_c4_op_count", 0, 32'(opc[0]), 32'd1);
    chk("basic_c4_no_reissue", 0, 32'(ustart[0]), 32'd0);
    chk("basic_c4_result", 0, 32'(resv[0]), 32'd0);
    tick(); @(negedge clk);
    chk("basic_c5_reissue", 0, 32'(ustart[0]), 32'd1);
    tick();

    // Downstream stall holds the result
    do_reset(0);
    issue[0] = 1'b1; isel[0] = 3'd6;
    @(negedge clk);
    chk("stall_c0_start", 0, 32'(ustart[0]), 32'd1);
    tick(); stop[0] = 1'b1;
    tick();
    tick();
    for (int c = 3; c <= 6; c++) begin
      stop[0] = (c <= 5);
      @(negedge clk);
      chk("stall_result_held", 0, 32'(resv[0]), 32'd1);
      chk("stall_no_stall_req", 0, 32'(stall[0]), 32'd0);
      chk("stall_count_pending", 0, 32'(opc[0]), 32'd0);
      tick();
    end
    issue[0] = 1'b0; stop[0] = 1'b0;
    @(negedge clk);
    chk("stall_c7_result", 0, 32'(resv[0]), 32'd0);
    chk("stall_c7_op_count", 0, 32'(opc[0]), 32'd1);
    tick();

    // Config write contends with issue
    do_reset(0);
    cfgv[0] = 1'b1; cidx[0] = 3'd4; cscale[0] = 5'h1F; issue[0] = 1'b1; isel[0] = 3'd5;
    @(negedge clk);
    chk("cont_cfg_ready", 0, 32'(cfg_ready[0]), 32'd1);
    chk("cont_write_enable", 0, 32'(uwe[0]), 32'd1);
    chk("cont_no_start", 0, 32'(ustart[0]), 32'd0);
    chk("cont_usel", 0, 32'(usel[0]), 32'd4);
    chk("cont_unew", 0, 32'(unew[0]), 32'h1F);
    tick(); cfgv[0] = 1'b0;
    @(negedge clk);
    chk("cont_start_next", 0, 32'(ustart[0]), 32'd1);
    tick(); tick(); tick();
    @(negedge clk);
    chk("cont_result", 0, 32'(resv[0]), 32'd1);
    chk("cont_result_usel", 0, 32'(usel[0]), 32'd5);
    tick(); issue[0] = 1'b0;
    tick();

    // Flush in the second BUSY cycle; config blocked while busy
    do_reset(0);
    issue[0] = 1'b1; isel[0] = 3'd1;
    @(negedge clk);
    chk("flush_c0_start", 0, 32'(ustart[0]), 32'd1);
    tick(); cfgv[0] = 1'b1; cidx[0] = 3'd2; cscale[0] = 5'h0A;
    @(negedge clk);
    chk("flush_busy_cfg_ready", 0, 32'(cfg_ready[0]), 32'd0);
    chk("flush_busy_write_enable", 0, 32'(uwe[0]), 32'd0);
    tick(); cfgv[0] = 1'b0; flush[0] = 1'b1; issue[0] = 1'b0;
    tick(); flush[0] = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      @(negedge clk);
      chk("flush_no_result", 0, 32'(resv[0]), 32'd0);
      chk("flush_no_stall", 0, 32'(stall[0]), 32'd0);
      chk("flush_op_count", 0, 32'(opc[0]), 32'd0);
      tick();
    end

    // Reset in the middle of an operation after one completed op
    do_reset(0);
    issue[0] = 1'b1; isel[0] = 3'd3;
    tick(); tick(); tick(); tick(); issue[0] = 1'b0;
    @(negedge clk);
    chk("rst_pre_op_count", 0, 32'(opc[0]), 32'd1);
    tick(); issue[0] = 1'b1; isel[0] = 3'd7;
    @(negedge clk);
    chk("rst_start", 0, 32'(ustart[0]), 32'd1);
    tick(); rstn[0] = 1'b0; cfgv[0] = 1'b1; cidx[0] = 3'd6; cscale[0] = 5'h15;
    @(negedge clk);
    check_zero_outputs("rst_mid", 0);
    tick(); rstn[0] = 1'b1; issue[0] = 1'b0; cfgv[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_after_result", 0, 32'(resv[0]), 32'd0);
      chk("rst_after_op_count", 0, 32'(opc[0]), 32'd0);
      tick();
    end

    // LATENCY 1 and op_count wrap
    do_reset(1);
    issue[1] = 1'b1; isel[1] = 3'd3;
    @(negedge clk);
    chk("lat1_start", 1, 32'(ustart[1]), 32'd1);
    tick();
    @(negedge clk);
    chk("lat1_result", 1, 32'(resv[1]), 32'd1);
    chk("lat1_usel", 1, 32'(usel[1]), 32'd3);
    tick(); issue[1] = 1'b0;
    @(negedge clk);
    chk("lat1_op_count", 1, 32'(opc[1]), 32'd1);
    tick();
    force u_dut1.op_count_q = 16'hFFFF;
    release u_dut1.op_count_q;
    m_cnt[1] = 16'hFFFF;
    @(negedge clk);
    chk("wrap_preload", 1, 32'(opc[1]), 32'h0000FFFF);
    tick(); issue[1] = 1'b1;
    tick();
    @(negedge clk);
    chk("wrap_result", 1, 32'(resv[1]), 32'd1);
    tick(); issue[1] = 1'b0;
    @(negedge clk);
    chk("wrap_op_count", 1, 32'(opc[1]), 32'd0);
    tick();

    // Randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        rstn[k]   = ($urandom_range(63) != 0);
        issue[k]  = ($urandom_range(3) != 0);
        isel[k]   = 3'($urandom_range(7));
        stop[k]   = ($urandom_range(2) == 0);
        flush[k]  = ($urandom_range(11) == 0);
        cfgv[k]   = ($urandom_range(5) == 0);
        cidx[k]   = 3'($urandom_range(7));
        cscale[k] = SW'($urandom_range(31));
      end
      tick();
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
